// File: rtl/prio_encoder_148_irq.sv
// 74LS148-style 8-to-3 priority encoder with synchronised edge capture and a valid/ack handshake.
// Each request line owns its synchroniser, pending bit and sticky overrun flag in one lane instance.
module prio_encoder_148_irq_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clr,
  input  logic clr_ovr,
  output logic pend,
  output logic ovr
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic req_d_q, req_d_d;
  logic pend_q, pend_d;
  logic ovr_q, ovr_d;
  logic rise;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], req};
    req_d_d = sync_q[SYNC_STAGES-1];
    rise    = sync_q[SYNC_STAGES-1] & ~req_d_q;
    // a same-cycle set beats the ack clear and is not an overrun
    pend_d  = rise ? 1'b1 : (clr ? 1'b0 : pend_q);
    ovr_d   = (rise & pend_q & ~clr) ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      req_d_q <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      req_d_q <= req_d_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pend = pend_q;
  assign ovr  = ovr_q;
endmodule

module prio_encoder_148_irq #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] I_n,
  input  logic       EI_n,
  input  logic       ack,
  input  logic       clr_ovr,
  output logic [2:0] code,
  output logic       valid,
  output logic       gs,
  output logic [7:0] pending,
  output logic [7:0] overrun
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [2:0]           code_q, code_d;
  logic [2:0]           hi_idx;
  logic [NUM_LANES-1:0] clr_vec;
  logic                 ack_clr;

  assign ack_clr = (state_q == HOLD) & ack;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign clr_vec[g] = ack_clr & (code_q == 3'(g));
    prio_encoder_148_irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .req     (~I_n[g]),
      .clr     (clr_vec[g]),
      .clr_ovr (clr_ovr),
      .pend    (pending[g]),
      .ovr     (overrun[g])
    );
  end

  // ascending scan, so the highest set bit wins
  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < NUM_LANES; i++)
      if (pending[i]) hi_idx = 3'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE: if (!EI_n && (pending != '0)) begin
        state_d = HOLD;
        code_d  = hi_idx;
      end
      HOLD: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == HOLD);
    code  = code_q;
    gs    = |pending;
  end
endmodule
